// File: rtl/multicycle_cu_if.sv
// rtl/multicycle_cu_if.sv - control-unit to datapath/memory signal bundle
interface multicycle_cu_if;
    logic [31:0] instr;
    logic        zero;
    logic        sign;
    logic        mem_ready;
    logic        mem_req;
    logic        MemWrite;
    logic        AdrSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic [1:0]  ResultSrc;
    logic        instr_done;
    logic        fault;

    modport master (
        input  instr, zero, sign, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, ResultSrc,
               instr_done, fault
    );

    modport slave (
        output instr, zero, sign, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, ResultSrc,
               instr_done, fault
    );
endinterface

// File: rtl/multicycle_cu.sv
// rtl/multicycle_cu.sv - multi-cycle RV32I subset control FSM with memory-wait timeout
module multicycle_cu #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_cu_if.master   bus
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b010;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_FAULT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] wcnt;
    logic            in_wait;
    logic            timed_out;
    logic            taken;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_instr;

    assign op           = bus.instr[6:0];
    assign funct3       = bus.instr[14:12];
    assign funct7b5     = bus.instr[30];
    assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    assign in_wait   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timed_out = (wcnt == TO_LIM) && !bus.mem_ready;
    assign taken     = ((funct3 == 3'b000) &&  bus.zero) ||
                       ((funct3 == 3'b001) && !bus.zero) ||
                       ((funct3 == 3'b100) &&  bus.sign);

    // funct3 -> ALU operation; sub_en only matters for funct3=000
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_en);
        logic [2:0] r;
        case (f3)
            3'b000:  r = sub_en ? ALU_SUB : ALU_ADD;
            3'b001:  r = 3'b001;
            3'b100:  r = 3'b100;
            3'b101:  r = 3'b101;
            3'b110:  r = 3'b110;
            3'b111:  r = 3'b111;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

    // state register and memory-wait counter; counter restarts on any wait-state entry or completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            if (in_wait && !bus.mem_ready && (state_next == state))
                wcnt <= wcnt + 1'b1;
            else
                wcnt <= '0;
        end
    end

    // next-state and Moore output decode, with mem_ready/flag qualifiers on enables
    always_comb begin
        state_next     = state;
        bus.mem_req    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = ALU_ADD;
        bus.ImmSrc     = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.instr_done = 1'b0;
        bus.fault      = 1'b0;

        case (state)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_next  = S_DECODE;
                end else if (timed_out) begin
                    state_next  = S_FAULT;
                end
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = 2'b10;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BR:        state_next = S_BRANCH;
                    default:      state_next = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = (op == OP_SW) ? 2'b01 : 2'b00;
                state_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
                if (bus.mem_ready)
                    state_next = S_MEMWB;
                else if (timed_out)
                    state_next = S_FAULT;
            end
            S_MEMWB: begin
                bus.ResultSrc  = 2'b01;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.MemWrite = 1'b1;
                bus.AdrSrc   = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end else if (timed_out) begin
                    state_next     = S_FAULT;
                end
            end
            S_EXECR: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = 2'b00;
                bus.ALUControl = alu_dec(funct3, funct7b5);
                state_next     = S_ALUWB;
            end
            S_EXECI: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_dec(funct3, 1'b0);
                state_next     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = 2'b00;
                bus.ALUControl = ALU_SUB;
                bus.PCWrite    = taken;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_FAULT: begin
                bus.fault = 1'b1;
            end
            default: begin
                state_next = S_FAULT;
            end
        endcase

        // reset quiesces every control output regardless of the current state
        if (!rst_n) begin
            bus.mem_req    = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.AdrSrc     = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.PCWrite    = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.ALUSrcA    = 2'b00;
            bus.ALUSrcB    = 2'b00;
            bus.ALUControl = ALU_ADD;
            bus.ImmSrc     = 2'b00;
            bus.ResultSrc  = 2'b00;
            bus.instr_done = 1'b0;
            bus.fault      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_cu.sv
// tb/tb_multicycle_cu.sv - scoreboard bench for multicycle_cu
module tb_multicycle_cu;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_cu_if bus ();

    multicycle_cu #(.TIMEOUT(15), .TO_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         cycles;
        int         memreq;
        int         memw;
        int         regw;
        logic [1:0] rsrc;
        logic [2:0] alu;
        int         taken;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // reference: instruction class + wait delays -> observable totals
    function automatic rec_t model(input logic [31:0] ins, input bit z, input bit s,
                                   input int fd, input int md);
        rec_t       r;
        logic [2:0] f3;
        logic [2:0] alu_tab [8];
        alu_tab = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
        f3 = ins[14:12];
        r = '{cycles: fd + 2, memreq: fd + 1, memw: 0, regw: 0, rsrc: 2'b00, alu: 3'b000, taken: 0};
        case (ins[6:0])
            OP_LW: begin
                r.cycles += md + 3; r.memreq += md + 1; r.regw = 1; r.rsrc = 2'b01;
            end
            OP_SW: begin
                r.cycles += md + 2; r.memreq += md + 1; r.memw = md + 1;
            end
            OP_R: begin
                r.cycles += 2; r.regw = 1;
                r.alu = (f3 == 3'b000 && ins[30]) ? 3'b010 : alu_tab[f3];
            end
            OP_I: begin
                r.cycles += 2; r.regw = 1; r.alu = alu_tab[f3];
            end
            default: begin
                r.cycles += 1; r.alu = 3'b010;
                r.taken = ((f3 == 3'b000 && z) || (f3 == 3'b001 && !z) || (f3 == 3'b100 && s)) ? 1 : 0;
            end
        endcase
        return r;
    endfunction

    // memory responder: ready after df (fetch) or dm (data) low cycles of a request
    int df = 0;
    int dm = 0;
    bit no_ready = 1'b0;
    int wcnt = 0;
    initial begin
        bus.mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !no_ready) begin
                if (wcnt == (bus.AdrSrc ? dm : df)) begin
                    bus.mem_ready = 1'b1;
                    wcnt = 0;
                end else begin
                    bus.mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // monitor: accumulate per-instruction activity, compare on retire
    bit         mon_en = 1'b0;
    int         c_cyc, c_mreq, c_mw, c_rw, c_tk;
    logic [1:0] c_rs;
    logic [2:0] c_alu;
    initial begin
        rec_t e;
        c_cyc = 0; c_mreq = 0; c_mw = 0; c_rw = 0; c_tk = 0; c_rs = 2'b00; c_alu = 3'b000;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n || !mon_en) begin
                c_cyc = 0; c_mreq = 0; c_mw = 0; c_rw = 0; c_tk = 0; c_rs = 2'b00; c_alu = 3'b000;
            end else begin
                c_cyc++;
                if (bus.mem_req)  c_mreq++;
                if (bus.MemWrite) c_mw++;
                if (bus.RegWrite) begin c_rw++; c_rs = bus.ResultSrc; end
                if (bus.ALUSrcA == 2'b10) c_alu = bus.ALUControl;
                if (bus.PCWrite && !bus.IRWrite) c_tk++;
                if (bus.RegWrite && bus.MemWrite) chk("regw_memw_together", 1, 0);
                if (bus.IRWrite && !(bus.PCWrite && bus.mem_req && !bus.AdrSrc))
                    chk("irwrite_outside_fetch", 1, 0);
                if (bus.instr_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cycles",     c_cyc,       e.cycles);
                        chk("mem_req",    c_mreq,      e.memreq);
                        chk("memwrite",   c_mw,        e.memw);
                        chk("regwrite",   c_rw,        e.regw);
                        chk("resultsrc",  int'(c_rs),  int'(e.rsrc));
                        chk("alucontrol", int'(c_alu), int'(e.alu));
                        chk("taken",      c_tk,        e.taken);
                    end
                    c_cyc = 0; c_mreq = 0; c_mw = 0; c_rw = 0; c_tk = 0; c_rs = 2'b00; c_alu = 3'b000;
                end
            end
        end
    end

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input bit b30);
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = op;
        w[14:12] = f3;
        w[30]    = b30;
        return w;
    endfunction

    task automatic issue(input logic [31:0] ins, input bit z, input bit s, input int fd, input int md);
        int n;
        bus.instr = ins;
        bus.zero  = z;
        bus.sign  = s;
        df = fd;
        dm = md;
        exp_q.push_back(model(ins, z, s, fd, md));
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.instr_done) break;
        end
        if (n >= 200) chk("retire_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int mr;
        int mw;
        logic [6:0] ops [5];
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR};
        bus.instr = '0;
        bus.zero  = 1'b0;
        bus.sign  = 1'b0;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mem_req",    bus.mem_req,    0);
        chk("rst_irwrite",    bus.IRWrite,    0);
        chk("rst_pcwrite",    bus.PCWrite,    0);
        chk("rst_instr_done", bus.instr_done, 0);
        chk("rst_alusrcb",    bus.ALUSrcB,    0);
        chk("rst_fault",      bus.fault,      0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // directed cases
        issue(mk(OP_R, 3'b000, 1'b0), 1'b0, 1'b0, 0, 0);
        issue(mk(OP_R, 3'b000, 1'b1), 1'b0, 1'b0, 0, 0);
        issue(mk(OP_I, 3'b000, 1'b1), 1'b0, 1'b0, 0, 0);
        issue(mk(OP_R, 3'b111, 1'b0), 1'b0, 1'b0, 0, 0);
        issue(mk(OP_R, 3'b110, 1'b0), 1'b0, 1'b0, 0, 0);
        issue(mk(OP_R, 3'b100, 1'b0), 1'b0, 1'b0, 0, 0);
        issue(mk(OP_R, 3'b001, 1'b0), 1'b0, 1'b0, 0, 0);
        issue(mk(OP_R, 3'b101, 1'b0), 1'b0, 1'b0, 0, 0);
        issue(mk(OP_LW, 3'b010, 1'b0), 1'b0, 1'b0, 0, 3);
        issue(mk(OP_BR, 3'b000, 1'b0), 1'b1, 1'b0, 0, 0);
        issue(mk(OP_BR, 3'b001, 1'b0), 1'b1, 1'b0, 0, 0);
        issue(mk(OP_BR, 3'b100, 1'b0), 1'b0, 1'b1, 0, 0);
        issue(mk(OP_R, 3'b010, 1'b0), 1'b0, 1'b0, 15, 0);
        issue(mk(OP_SW, 3'b010, 1'b0), 1'b0, 1'b0, 2, 15);
        issue(mk(OP_LW, 3'b010, 1'b0), 1'b0, 1'b0, 1, 15);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            int fd;
            int md;
            op = ops[$urandom_range(0, 4)];
            f3 = 3'($urandom_range(0, 7));
            fd = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
            md = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
            issue(mk(op, f3, 1'($urandom_range(0, 1))), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), fd, md);
        end
        chk("queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // fetch timeout: 16 cycles without mem_ready traps to FAULT
        do_reset();
        no_ready = 1'b1;
        bus.instr = mk(OP_R, 3'b000, 1'b0);
        rst_n = 1'b1;
        n = 0;
        mr = 0;
        while (n < 40) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.fault) break;
            if (bus.mem_req) mr++;
        end
        chk("timeout_cycle", n, 17);
        chk("timeout_reqs", mr, 16);
        no_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("fault_sticky", bus.fault, 1);
            chk("fault_no_req", bus.mem_req | bus.PCWrite | bus.RegWrite, 0);
        end

        // illegal opcode faults right after DECODE
        do_reset();
        chk("fault_cleared", bus.fault, 0);
        bus.instr = mk(7'b1111111, 3'b000, 1'b0);
        df = 0;
        rst_n = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.fault) break;
        end
        chk("illegal_cycle", n, 3);

        // reset while in MEMWR aborts the store
        do_reset();
        bus.instr = mk(OP_SW, 3'b010, 1'b0);
        df = 0;
        dm = 10;
        rst_n = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.MemWrite) break;
        end
        chk("reach_memwr", n, 4);
        df = 50;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_memwrite", bus.MemWrite, 0);
        chk("rst_mid_done",     bus.instr_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("after_rst_fetch_req", bus.mem_req, 1);
        chk("after_rst_adrsrc",    bus.AdrSrc,  0);
        chk("after_rst_fault",     bus.fault,   0);
        mw = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.MemWrite || bus.RegWrite || bus.instr_done) mw++;
            @(negedge clk);
            #1;
        end
        chk("after_rst_no_write", mw, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
